nes_pixel_palette_sel: RTL and testbench

//  NES PPU pixel-priority/palette-address stage, directly upstream of the 32-entry

---
 rtl/nes_pixel_palette_sel.sv | 150 +++++++++++++++
 tb/tb_nes_pixel_palette_sel.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pixel_palette_sel.sv
// NES PPU pixel-priority / palette-address stage.
// Merges background and sprite pixels, drives the clocked palette ROM address,
// aligns pixel position with the ROM data, and registers the final colour index.
// Also keeps the sticky sprite-0 hit flag.
module nes_pixel_palette_sel #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          pix_valid,
    input  logic [XW-1:0] pix_x,
    input  logic [YW-1:0] pix_y,
    input  logic [1:0]    bg_pix,
    input  logic [1:0]    bg_pal,
    input  logic [1:0]    spr_pix,
    input  logic [1:0]    spr_pal,
    input  logic          spr_behind,
    input  logic          spr_is0,
    input  logic          show_bg,
    input  logic          show_spr,
    input  logic          show_bg_l8,
    input  logic          show_spr_l8,
    input  logic          grayscale,
    output logic [4:0]    pal_addr,
    input  logic [7:0]    pal_dout,
    output logic          out_valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic [5:0]    out_color,
    output logic          spr0_hit
);

    localparam logic [XW-1:0] X_CLIP = XW'(8);
    localparam logic [XW-1:0] X_LAST = XW'(255);

    logic          bg_op;
    logic          spr_op;
    logic          hit_cond;
    logic [4:0]    addr_sel;

    logic [4:0]    pal_addr_d,  pal_addr_q;
    logic          valid_s1_d,  valid_s1_q;
    logic [XW-1:0] x_s1_d,      x_s1_q;
    logic [YW-1:0] y_s1_d,      y_s1_q;
    logic          gray_s1_d,   gray_s1_q;
    logic          valid_s2_d,  valid_s2_q;
    logic [XW-1:0] x_s2_d,      x_s2_q;
    logic [YW-1:0] y_s2_d,      y_s2_q;
    logic          gray_s2_d,   gray_s2_q;
    logic          out_valid_d, out_valid_q;
    logic [XW-1:0] out_x_d,     out_x_q;
    logic [YW-1:0] out_y_d,     out_y_q;
    logic [5:0]    out_color_d, out_color_q;
    logic          spr0_hit_d,  spr0_hit_q;

    // The ROM's top two bits carry no colour information.
    logic          pal_dout_unused;
    assign pal_dout_unused = ^pal_dout[7:6];

    // Opacity, priority and palette address selection for the incoming pixel.
    always_comb begin
        bg_op    = pix_valid & show_bg & (bg_pix != 2'd0)
                   & ((pix_x >= X_CLIP) | show_bg_l8);
        spr_op   = pix_valid & show_spr & (spr_pix != 2'd0)
                   & ((pix_x >= X_CLIP) | show_spr_l8);
        hit_cond = bg_op & spr_op & spr_is0 & (pix_x != X_LAST);
        addr_sel = 5'h00;
        // Sprite wins unless it sits behind an opaque background; a transparent
        // pixel pair falls back to the universal backdrop, never to 10/14/18/1C.
        if (spr_op && (!bg_op || !spr_behind)) begin
            addr_sel = {1'b1, spr_pal, spr_pix};
        end else if (bg_op) begin
            addr_sel = {1'b0, bg_pal, bg_pix};
        end
        pal_addr_d = pix_valid ? addr_sel : pal_addr_q;
    end

    // Next-state for the alignment pipeline, output registers and hit flag.
    always_comb begin
        valid_s1_d  = pix_valid;
        x_s1_d      = pix_x;
        y_s1_d      = pix_y;
        gray_s1_d   = grayscale;
        valid_s2_d  = valid_s1_q;
        x_s2_d      = x_s1_q;
        y_s2_d      = y_s1_q;
        gray_s2_d   = gray_s1_q;
        out_valid_d = valid_s2_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_color_d = out_color_q;
        if (valid_s2_q) begin
            out_x_d     = x_s2_q;
            out_y_d     = y_s2_q;
            out_color_d = gray_s2_q ? (pal_dout[5:0] & 6'h30) : pal_dout[5:0];
        end
        // Clear has priority over a coincident hit.
        spr0_hit_d = spr0_hit_q;
        if (frame_start) begin
            spr0_hit_d = 1'b0;
        end else if (hit_cond) begin
            spr0_hit_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pal_addr_q  <= 5'h00;
            valid_s1_q  <= 1'b0;
            x_s1_q      <= '0;
            y_s1_q      <= '0;
            gray_s1_q   <= 1'b0;
            valid_s2_q  <= 1'b0;
            x_s2_q      <= '0;
            y_s2_q      <= '0;
            gray_s2_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_color_q <= 6'h00;
            spr0_hit_q  <= 1'b0;
        end else begin
            pal_addr_q  <= pal_addr_d;
            valid_s1_q  <= valid_s1_d;
            x_s1_q      <= x_s1_d;
            y_s1_q      <= y_s1_d;
            gray_s1_q   <= gray_s1_d;
            valid_s2_q  <= valid_s2_d;
            x_s2_q      <= x_s2_d;
            y_s2_q      <= y_s2_d;
            gray_s2_q   <= gray_s2_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_color_q <= out_color_d;
            spr0_hit_q  <= spr0_hit_d;
        end
    end

    assign pal_addr  = pal_addr_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_color = out_color_q;
    assign spr0_hit  = spr0_hit_q;

endmodule

// File: tb/tb_nes_pixel_palette_sel.sv
// Testbench for nes_pixel_palette_sel: clocked palette ROM, a per-pixel
// reference model with a latency queue, an every-cycle compare process and
// directed literal checks.
module tb_nes_pixel_palette_sel;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       pix_valid;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic [1:0] bg_pix, bg_pal, spr_pix, spr_pal;
    logic       spr_behind, spr_is0;
    logic       show_bg, show_spr, show_bg_l8, show_spr_l8, grayscale;
    logic [4:0] pal_addr;
    logic [7:0] pal_dout;
    logic       out_valid;
    logic [8:0] out_x;
    logic [7:0] out_y;
    logic [5:0] out_color;
    logic       spr0_hit;

    int ncmp = 0;
    int nerr = 0;

    nes_pixel_palette_sel #(.XW(9), .YW(8)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .bg_pix(bg_pix), .bg_pal(bg_pal),
        .spr_pix(spr_pix), .spr_pal(spr_pal), .spr_behind(spr_behind),
        .spr_is0(spr_is0), .show_bg(show_bg), .show_spr(show_spr),
        .show_bg_l8(show_bg_l8), .show_spr_l8(show_spr_l8), .grayscale(grayscale),
        .pal_addr(pal_addr), .pal_dout(pal_dout), .out_valid(out_valid),
        .out_x(out_x), .out_y(out_y), .out_color(out_color), .spr0_hit(spr0_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Palette ROM: entries carry junk in bits 7:6 so those must be ignored.
    logic [7:0] rom [32];
    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'hC0 | 8'((i * 7 + 3) & 63);
        rom[1] = 8'h2D;
        rom[5] = 8'h27;
    end
    always @(posedge clk) pal_dout <= rom[pal_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [5:0] c;
        logic [8:0] x;
        logic [7:0] y;
    } pix_t;

    pix_t       pipe[$];
    logic       chk_en = 1'b0;
    logic [4:0] m_addr;
    logic       m_valid, m_hit;
    logic [5:0] m_color;
    logic [8:0] m_x;
    logic [7:0] m_y;

    function automatic logic [4:0] ref_addr(input logic [8:0] x,
            input logic [1:0] bp, input logic [1:0] bl, input logic [1:0] sp,
            input logic [1:0] sl, input logic behind, input logic sb, input logic ss,
            input logic bl8, input logic sl8);
        logic bvis, svis;
        bvis = sb && bp != 0 && (x > 7 || bl8);
        svis = ss && sp != 0 && (x > 7 || sl8);
        if (svis && !(bvis && behind)) return {1'b1, sl, sp};
        if (bvis) return {1'b0, bl, bp};
        return 5'h00;
    endfunction

    // Each pixel's final colour is known at input time; the queue supplies the
    // three-cycle latency (two entries stay in flight between edges).
    always @(posedge clk) begin
        pix_t n, due;
        logic [4:0] a;
        logic bvis, svis;
        if (rst) begin
            pipe.delete();
            pipe.push_back('0);
            pipe.push_back('0);
            m_addr = 0; m_valid = 0; m_color = 0; m_x = 0; m_y = 0; m_hit = 0;
            chk_en = 1'b1;
        end else begin
            a = ref_addr(pix_x, bg_pix, bg_pal, spr_pix, spr_pal, spr_behind,
                         show_bg, show_spr, show_bg_l8, show_spr_l8);
            n.v = pix_valid;
            n.c = rom[a][5:0] & (grayscale ? 6'h30 : 6'h3F);
            n.x = pix_x;
            n.y = pix_y;
            pipe.push_back(n);
            due = pipe.pop_front();
            m_valid = due.v;
            if (due.v) begin
                m_color = due.c; m_x = due.x; m_y = due.y;
            end
            if (pix_valid) m_addr = a;
            bvis = pix_valid && show_bg && bg_pix != 0 && (pix_x > 7 || show_bg_l8);
            svis = pix_valid && show_spr && spr_pix != 0 && (pix_x > 7 || show_spr_l8);
            if (frame_start) m_hit = 0;
            else if (bvis && svis && spr_is0 && pix_x != 255) m_hit = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pal_addr", 32'(pal_addr), 32'(m_addr));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_color", 32'(out_color), 32'(m_color));
            check("out_x", 32'(out_x), 32'(m_x));
            check("out_y", 32'(out_y), 32'(m_y));
            check("spr0_hit", 32'(spr0_hit), 32'(m_hit));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic v, input int x, input logic [1:0] bp,
            input logic [1:0] bl, input logic [1:0] sp, input logic [1:0] sl,
            input logic behind, input logic is0);
        pix_valid = v; pix_x = 9'(x); pix_y = 8'(x % 240);
        bg_pix = bp; bg_pal = bl; spr_pix = sp; spr_pal = sl;
        spr_behind = behind; spr_is0 = is0;
    endtask

    initial begin
        rst = 1; frame_start = 0; grayscale = 0;
        show_bg = 1; show_spr = 1; show_bg_l8 = 1; show_spr_l8 = 1;
        set_pix(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        rst = 0;
        step();

        // T2 priority
        set_pix(1, 20, 2, 1, 3, 2, 0, 0); step(); check("t2_spr_front", 32'(pal_addr), 32'h1B);
        set_pix(1, 21, 2, 1, 3, 2, 1, 0); step(); check("t2_spr_behind", 32'(pal_addr), 32'h06);
        set_pix(1, 22, 0, 1, 0, 2, 0, 0); step(); check("t2_both_clear", 32'(pal_addr), 32'h00);
        set_pix(1, 23, 0, 1, 0, 3, 0, 0); step(); check("t2_spr_pal3", 32'(pal_addr), 32'h00);
        set_pix(1, 24, 2, 1, 0, 0, 0, 0); step();
        set_pix(0, 25, 0, 0, 0, 0, 0, 0); step(); check("t2_hold", 32'(pal_addr), 32'h06);

        // T4 left-column clipping
        show_bg_l8 = 0;
        set_pix(1, 7, 1, 0, 0, 0, 0, 0); step(); check("t4_bg_x7", 32'(pal_addr), 32'h00);
        set_pix(1, 8, 1, 0, 0, 0, 0, 0); step(); check("t4_bg_x8", 32'(pal_addr), 32'h01);
        show_bg_l8 = 1; show_spr_l8 = 0;
        set_pix(1, 7, 0, 0, 1, 0, 0, 0); step(); check("t4_spr_x7", 32'(pal_addr), 32'h00);
        set_pix(1, 8, 0, 0, 1, 0, 0, 0); step(); check("t4_spr_x8", 32'(pal_addr), 32'h11);
        show_spr_l8 = 1;

        // T3 latency / throughput
        for (int i = 0; i < 258; i++) begin
            if (i < 256) set_pix(1, i, 1, 0, 0, 0, 0, 0);
            else set_pix(0, 0, 0, 0, 0, 0, 0, 0);
            step();
            if (i >= 2) begin
                check("t3_valid", 32'(out_valid), 32'h1);
                check("t3_x", 32'(out_x), 32'(i - 2));
                check("t3_color", 32'(out_color), 32'h2D);
            end
        end
        step();
        check("t3_drain", 32'(out_valid), 32'h0);

        // T5 sprite-0 hit
        set_pix(1, 255, 1, 0, 1, 0, 0, 1); step(); check("t5_x255", 32'(spr0_hit), 32'h0);
        set_pix(1, 100, 1, 0, 1, 0, 1, 1); step(); check("t5_hit", 32'(spr0_hit), 32'h1);
        set_pix(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("t5_sticky", 32'(spr0_hit), 32'h1);
        frame_start = 1;
        set_pix(1, 101, 1, 0, 1, 0, 0, 1); step(); check("t5_clear_wins", 32'(spr0_hit), 32'h0);
        frame_start = 0;
        set_pix(1, 50, 2, 0, 2, 0, 0, 1); step(); check("t5_rehit", 32'(spr0_hit), 32'h1);

        // T6 grayscale follows the originating pixel
        grayscale = 1;
        set_pix(1, 40, 1, 1, 0, 0, 0, 0); step();
        grayscale = 0;
        set_pix(0, 0, 0, 0, 0, 0, 0, 0); step(); step();
        check("t6_gray", 32'(out_color), 32'h20);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                set_pix(1, 60 + i, 1, 1, 0, 0, 0, 0);
                grayscale = (i % 2 == 0);
            end else begin
                set_pix(0, 0, 0, 0, 0, 0, 0, 0);
                grayscale = (i % 2 == 1);
            end
            step();
            if (i >= 2) check("t6_toggle", 32'(out_color), ((i - 2) % 2 == 0) ? 32'h20 : 32'h27);
        end
        grayscale = 0;

        // T1 reset mid-stream (frame_start coincident on first reset cycle)
        set_pix(1, 10, 1, 0, 0, 0, 0, 0); step();
        set_pix(1, 11, 1, 0, 0, 0, 0, 0); step();
        rst = 1; frame_start = 1;
        set_pix(1, 12, 1, 0, 0, 0, 0, 0); step();
        frame_start = 0;
        set_pix(1, 13, 1, 0, 0, 0, 0, 0); step();
        check("t1_addr", 32'(pal_addr), 32'h0);
        check("t1_valid", 32'(out_valid), 32'h0);
        check("t1_color", 32'(out_color), 32'h0);
        check("t1_x", 32'(out_x), 32'h0);
        check("t1_hit", 32'(spr0_hit), 32'h0);
        rst = 0;
        set_pix(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_no_emit", 32'(out_valid), 32'h0);
        end

        // Mixed sweep checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            set_pix($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                    2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    1'($urandom), $urandom_range(0, 3) == 0);
            pix_y = 8'($urandom_range(0, 239));
            frame_start = ($urandom_range(0, 15) == 0);
            grayscale = 1'($urandom);
            show_bg = ($urandom_range(0, 3) != 0);
            show_spr = ($urandom_range(0, 3) != 0);
            show_bg_l8 = 1'($urandom);
            show_spr_l8 = 1'($urandom);
            step();
        end
        frame_start = 0;
        set_pix(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
